// File: rtl/mvu_csr_pkg.sv
// Shared register map, field widths and STATUS bit positions for the MVU APB CSR block.
// Optional build macro used by the block: MVU_CSR_PERFCNT_EN (per-MVU BUSYCYC counter).
package mvu_csr_pkg;

  localparam int MVU_NMVU_DEF = 8;
  localparam int MVU_DATA_W   = 32;
  localparam int MVU_PREC_W   = 5;
  localparam int MVU_BADDR_W  = 15;
  localparam int MVU_CNT_W    = 15;
  localparam int MVU_PREC_MAX = 16;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_IRQ_BIT  = 1;

  // Word index within one MVU's 256-byte window (paddr[7:2]).
  typedef enum logic [5:0] {
    REG_CTRL      = 6'd0,
    REG_STATUS    = 6'd1,
    REG_WPREC     = 6'd2,
    REG_IPREC     = 6'd3,
    REG_OPREC     = 6'd4,
    REG_WBADDR    = 6'd5,
    REG_IBADDR    = 6'd6,
    REG_OBADDR    = 6'd7,
    REG_COUNTDOWN = 6'd8,
    REG_IRQ_EN    = 6'd9,
    REG_BUSYCYC   = 6'd10
  } reg_e;

  function automatic logic is_prec_reg(input reg_e r);
    return (r == REG_WPREC) || (r == REG_IPREC) || (r == REG_OPREC);
  endfunction

endpackage

// File: rtl/mvu_csr_bank.sv
// One MVU channel: job configuration, busy/irq tracking and start pulse generation.
// With MVU_CSR_PERFCNT_EN defined, also a saturating count of busy cycles.
module mvu_csr_bank
  import mvu_csr_pkg::*;
#(
  parameter int PREC_W  = MVU_PREC_W,
  parameter int BADDR_W = MVU_BADDR_W,
  parameter int CNT_W   = MVU_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  reg_e               wr_reg,
  input  logic [31:0]        wr_data,
  input  logic               mvu_done,
  output logic               mvu_start,
  output logic               busy,
  output logic               irq,
  output logic               irq_en,
`ifdef MVU_CSR_PERFCNT_EN
  output logic [31:0]        busycyc,
`endif
  output logic [PREC_W-1:0]  wprec,
  output logic [PREC_W-1:0]  iprec,
  output logic [PREC_W-1:0]  oprec,
  output logic [BADDR_W-1:0] wbaddr,
  output logic [BADDR_W-1:0] ibaddr,
  output logic [BADDR_W-1:0] obaddr,
  output logic [CNT_W-1:0]   countdown
);

  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic               pend_q, pend_d;
  logic               en_q, en_d;
  logic [PREC_W-1:0]  wprec_q, wprec_d, iprec_q, iprec_d, oprec_q, oprec_d;
  logic [BADDR_W-1:0] wbaddr_q, wbaddr_d, ibaddr_q, ibaddr_d, obaddr_q, obaddr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic unused_wr_data;
  assign unused_wr_data = ^wr_data;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
    start_d  = 1'b0;
    busy_d   = busy_q;
    pend_d   = pend_q;
    en_d     = en_q;
    wprec_d  = wprec_q;
    iprec_d  = iprec_q;
    oprec_d  = oprec_q;
    wbaddr_d = wbaddr_q;
    ibaddr_d = ibaddr_q;
    obaddr_d = obaddr_q;
    cnt_d    = cnt_q;
    if (wr_en) begin
      case (wr_reg)
        REG_CTRL:      start_d  = wr_data[0];
        REG_STATUS:    if (wr_data[STAT_IRQ_BIT]) pend_d = 1'b0;
        REG_WPREC:     wprec_d  = wr_data[PREC_W-1:0];
        REG_IPREC:     iprec_d  = wr_data[PREC_W-1:0];
        REG_OPREC:     oprec_d  = wr_data[PREC_W-1:0];
        REG_WBADDR:    wbaddr_d = wr_data[BADDR_W-1:0];
        REG_IBADDR:    ibaddr_d = wr_data[BADDR_W-1:0];
        REG_OBADDR:    obaddr_d = wr_data[BADDR_W-1:0];
        REG_COUNTDOWN: cnt_d    = wr_data[CNT_W-1:0];
        REG_IRQ_EN:    en_d     = wr_data[0];
        default:       ;
      endcase
    end
    // Done after the W1C so a same-cycle completion keeps the interrupt pending.
    if (mvu_done && busy_q) begin
      busy_d = 1'b0;
      if (en_q) pend_d = 1'b1;
    end
    if (start_d) busy_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      pend_q   <= 1'b0;
      en_q     <= 1'b0;
      wprec_q  <= '0;
      iprec_q  <= '0;
      oprec_q  <= '0;
      wbaddr_q <= '0;
      ibaddr_q <= '0;
      obaddr_q <= '0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking here so every flop samples the pre-edge values of its peers.
      start_q  <= start_d;
      busy_q   <= busy_d;
      pend_q   <= pend_d;
      en_q     <= en_d;
      wprec_q  <= wprec_d;
      iprec_q  <= iprec_d;
      oprec_q  <= oprec_d;
      wbaddr_q <= wbaddr_d;
      ibaddr_q <= ibaddr_d;
      obaddr_q <= obaddr_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef MVU_CSR_PERFCNT_EN
  logic [31:0] busycyc_q, busycyc_d;

  always_comb begin
    busycyc_d = busycyc_q;
    if (start_d)                         busycyc_d = '0;
    else if (busy_q && busycyc_q != '1)  busycyc_d = busycyc_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busycyc_q <= '0;
    else     busycyc_q <= busycyc_d;
  end

  assign busycyc = busycyc_q;
`endif

  assign mvu_start = start_q;
  assign busy      = busy_q;
  assign irq       = pend_q;
  assign irq_en    = en_q;
  assign wprec     = wprec_q;
  assign iprec     = iprec_q;
  assign oprec     = oprec_q;
  assign wbaddr    = wbaddr_q;
  assign ibaddr    = ibaddr_q;
  assign obaddr    = obaddr_q;
  assign countdown = cnt_q;

endmodule

// File: rtl/mvu_apb_csr.sv
// APB slave fronting NMVU matrix-vector units: address decode, error checks and read mux.
// Optional build macro: MVU_CSR_PERFCNT_EN maps a read-only BUSYCYC counter at offset 0x28.
module mvu_apb_csr
  import mvu_csr_pkg::*;
#(
  parameter int NMVU       = MVU_NMVU_DEF,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = MVU_DATA_W,
  parameter int PREC_W     = MVU_PREC_W,
  parameter int BADDR_W    = MVU_BADDR_W,
  parameter int CNT_W      = MVU_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr,
  input  logic [NMVU-1:0]         mvu_done,
  output logic [NMVU-1:0]         mvu_start,
  output logic [NMVU*PREC_W-1:0]  wprec,
  output logic [NMVU*PREC_W-1:0]  iprec,
  output logic [NMVU*PREC_W-1:0]  oprec,
  output logic [NMVU*BADDR_W-1:0] wbaddr,
  output logic [NMVU*BADDR_W-1:0] ibaddr,
  output logic [NMVU*BADDR_W-1:0] obaddr,
  output logic [NMVU*CNT_W-1:0]   countdown,
  output logic [NMVU-1:0]         irq
);

  logic                  access;
  logic [3:0]            mvu_idx;
  reg_e                  reg_idx;
  logic [NMVU-1:0]       busy, irq_en, wr_en;
  logic                  sel_busy, mvu_ok, reg_ok, wr_bad, err;
  logic [DATA_WIDTH-1:0] rd_word;
`ifdef MVU_CSR_PERFCNT_EN
  logic [31:0]           busycyc [NMVU];
`endif

  assign access  = psel & penable;
  assign mvu_idx = paddr[11:8];
  assign reg_idx = reg_e'(paddr[7:2]);

  logic unused_paddr;
  assign unused_paddr = ^{paddr[ADDR_WIDTH-1:12], paddr[1:0]};

  for (genvar i = 0; i < NMVU; i++) begin : g_bank
    mvu_csr_bank #(
      .PREC_W (PREC_W),
      .BADDR_W(BADDR_W),
      .CNT_W  (CNT_W)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en[i]),
      .wr_reg   (reg_idx),
      .wr_data  (pwdata),
      .mvu_done (mvu_done[i]),
      .mvu_start(mvu_start[i]),
      .busy     (busy[i]),
      .irq      (irq[i]),
      .irq_en   (irq_en[i]),
`ifdef MVU_CSR_PERFCNT_EN
      .busycyc  (busycyc[i]),
`endif
      .wprec    (wprec[i*PREC_W +: PREC_W]),
      .iprec    (iprec[i*PREC_W +: PREC_W]),
      .oprec    (oprec[i*PREC_W +: PREC_W]),
      .wbaddr   (wbaddr[i*BADDR_W +: BADDR_W]),
      .ibaddr   (ibaddr[i*BADDR_W +: BADDR_W]),
      .obaddr   (obaddr[i*BADDR_W +: BADDR_W]),
      .countdown(countdown[i*CNT_W +: CNT_W])
    );
  end

  // Selected-channel read word and busy flag; an out-of-range index selects nothing.
  always_comb begin
    sel_busy = 1'b0;
    rd_word  = '0;
    for (int i = 0; i < NMVU; i++) begin
      if (mvu_idx == 4'(i)) begin
        sel_busy = busy[i];
        case (reg_idx)
          REG_STATUS: begin
            rd_word[STAT_BUSY_BIT] = busy[i];
            rd_word[STAT_IRQ_BIT]  = irq[i];
          end
          REG_WPREC:     rd_word = DATA_WIDTH'(wprec[i*PREC_W +: PREC_W]);
          REG_IPREC:     rd_word = DATA_WIDTH'(iprec[i*PREC_W +: PREC_W]);
          REG_OPREC:     rd_word = DATA_WIDTH'(oprec[i*PREC_W +: PREC_W]);
          REG_WBADDR:    rd_word = DATA_WIDTH'(wbaddr[i*BADDR_W +: BADDR_W]);
          REG_IBADDR:    rd_word = DATA_WIDTH'(ibaddr[i*BADDR_W +: BADDR_W]);
          REG_OBADDR:    rd_word = DATA_WIDTH'(obaddr[i*BADDR_W +: BADDR_W]);
          REG_COUNTDOWN: rd_word = DATA_WIDTH'(countdown[i*CNT_W +: CNT_W]);
          REG_IRQ_EN:    rd_word = DATA_WIDTH'(irq_en[i]);
`ifdef MVU_CSR_PERFCNT_EN
          REG_BUSYCYC:   rd_word = DATA_WIDTH'(busycyc[i]);
`endif
          default:       rd_word = '0;
        endcase
      end
    end
  end

  always_comb begin
    mvu_ok = (int'(mvu_idx) < NMVU);
`ifdef MVU_CSR_PERFCNT_EN
    reg_ok = (reg_idx <= REG_BUSYCYC);
    wr_bad = (reg_idx == REG_BUSYCYC);
`else
    reg_ok = (reg_idx <= REG_IRQ_EN);
    wr_bad = 1'b0;
`endif
    if (is_prec_reg(reg_idx) && (pwdata == '0 || pwdata > DATA_WIDTH'(MVU_PREC_MAX))) wr_bad = 1'b1;
    if (reg_idx == REG_CTRL && pwdata[0] && sel_busy) wr_bad = 1'b1;
    err = access && (!mvu_ok || !reg_ok || (pwrite && wr_bad));
    wr_en = '0;
    for (int i = 0; i < NMVU; i++) begin
      wr_en[i] = access && pwrite && !err && (mvu_idx == 4'(i));
    end
  end

  assign pready  = 1'b1;
  assign pslverr = err;
  assign prdata  = (access && !pwrite && !err) ? rd_word : '0;

endmodule

// File: tb/tb_mvu_apb_csr.sv
// Randomized and directed bench for mvu_apb_csr against a register-level reference model.
// Honors MVU_CSR_PERFCNT_EN the same way the design does.
module tb_mvu_apb_csr;

  localparam int NMVU = 8;
  localparam int PW   = 5;
  localparam int BW   = 15;
  localparam int CW   = 15;
`ifdef MVU_CSR_PERFCNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic pready, pslverr;
  logic [NMVU-1:0] mvu_done, mvu_start, irq;
  logic [NMVU*PW-1:0] wprec, iprec, oprec;
  logic [NMVU*BW-1:0] wbaddr, ibaddr, obaddr;
  logic [NMVU*CW-1:0] countdown;

  mvu_apb_csr #(.NMVU(NMVU)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .mvu_done(mvu_done), .mvu_start(mvu_start),
    .wprec(wprec), .iprec(iprec), .oprec(oprec),
    .wbaddr(wbaddr), .ibaddr(ibaddr), .obaddr(obaddr),
    .countdown(countdown), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: register contents per MVU, indexed by word offset.
  int unsigned     m_cfg [NMVU][11];
  bit              m_busy[NMVU];
  bit              m_pend[NMVU];
  bit              m_en  [NMVU];
  int unsigned     m_bc  [NMVU];
  logic [NMVU-1:0] m_start;

  logic [NMVU-1:0] s_start, s_irq;
  logic            s_err;
  logic [31:0]     s_rd;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int unsigned field_mask(input int r);
    case (r)
      2, 3, 4:    return (32'd1 << PW) - 1;
      5, 6, 7:    return (32'd1 << BW) - 1;
      8:          return (32'd1 << CW) - 1;
      9:          return 32'd1;
      default:    return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] a(input int mv, input int r);
    return {20'd0, 4'(mv), 6'(r), 2'b00};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NMVU; i++) begin
      m_busy[i] = 0; m_pend[i] = 0; m_en[i] = 0; m_bc[i] = 0;
      for (int r = 0; r < 11; r++) m_cfg[i][r] = 0;
    end
    m_start = '0;
  endtask

  task automatic model_resp(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                            output bit err, output logic [31:0] rd);
    int mv = int'(addr[11:8]);
    int r  = int'(addr[7:2]);
    err = 0;
    rd  = 0;
    if (mv >= NMVU) err = 1;
    else if (!(r <= 9 || (PERF && r == 10))) err = 1;
    else if (wr) begin
      if (r >= 2 && r <= 4 && (data == 0 || data > 16)) err = 1;
      if (r == 0 && data[0] && m_busy[mv]) err = 1;
      if (r == 10) err = 1;
    end else begin
      case (r)
        0:       rd = 0;
        1:       rd = {30'd0, m_pend[mv], m_busy[mv]};
        10:      rd = m_bc[mv];
        default: rd = m_cfg[mv][r];
      endcase
    end
  endtask

  task automatic model_step(input bit acc, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [NMVU-1:0] done);
    bit err;
    logic [31:0] rd;
    bit ob[NMVU];
    bit oe[NMVU];
    int mv, r;
    ob = m_busy;
    oe = m_en;
    m_start = '0;
    if (acc) begin
      model_resp(wr, addr, data, err, rd);
      mv = int'(addr[11:8]);
      r  = int'(addr[7:2]);
      if (wr && !err) begin
        case (r)
          0:       if (data[0]) m_start[mv] = 1'b1;
          1:       if (data[1]) m_pend[mv] = 0;
          default: m_cfg[mv][r] = data & field_mask(r);
        endcase
        if (r == 9) m_en[mv] = data[0];
      end
    end
    for (int i = 0; i < NMVU; i++) begin
      if (done[i] && ob[i]) begin
        m_busy[i] = 0;
        if (oe[i]) m_pend[i] = 1;
      end
      if (m_start[i]) begin
        m_busy[i] = 1;
        m_bc[i] = 0;
      end else if (ob[i] && m_bc[i] != 32'hFFFF_FFFF) m_bc[i]++;
    end
  endtask

  task automatic check_outputs();
    logic [NMVU*PW-1:0] ew, ei, eo;
    logic [NMVU*BW-1:0] ewb, eib, eob;
    logic [NMVU*CW-1:0] ec;
    logic [NMVU-1:0]    eirq;
    for (int i = 0; i < NMVU; i++) begin
      ew [i*PW +: PW] = PW'(m_cfg[i][2]);
      ei [i*PW +: PW] = PW'(m_cfg[i][3]);
      eo [i*PW +: PW] = PW'(m_cfg[i][4]);
      ewb[i*BW +: BW] = BW'(m_cfg[i][5]);
      eib[i*BW +: BW] = BW'(m_cfg[i][6]);
      eob[i*BW +: BW] = BW'(m_cfg[i][7]);
      ec [i*CW +: CW] = CW'(m_cfg[i][8]);
      eirq[i]         = m_pend[i];
    end
    check("mvu_start", mvu_start, m_start);
    check("irq", irq, eirq);
    check("wprec", wprec, ew);
    check("iprec", iprec, ei);
    check("oprec", oprec, eo);
    check("wbaddr", wbaddr, ewb);
    check("ibaddr", ibaddr, eib);
    check("obaddr", obaddr, eob);
    check("countdown", countdown, ec);
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic cycle(input bit sel, input bit en, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [NMVU-1:0] done);
    bit e_err;
    logic [31:0] e_rd;
    psel = sel; penable = en; pwrite = wr; paddr = addr; pwdata = data; mvu_done = done;
    #1;
    e_err = 0;
    e_rd  = 0;
    if (sel && en) model_resp(wr, addr, data, e_err, e_rd);
    s_err = pslverr;
    s_rd  = prdata;
    check("pslverr", pslverr, e_err);
    check("prdata", prdata, e_rd);
    check("pready", pready, 1'b1);
    @(posedge clk);
    model_step(sel && en, wr, addr, data, done);
    #1;
    check_outputs();
    s_start = mvu_start;
    s_irq   = irq;
    @(negedge clk);
  endtask

  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [NMVU-1:0] done);
    cycle(1'b1, 1'b0, wr, addr, data, '0);
    cycle(1'b1, 1'b1, wr, addr, data, done);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, '0);
  endtask

  task automatic do_reset();
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; mvu_done = '0;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check("rst_prdata", prdata, 32'd0);
    check("rst_pslverr", pslverr, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; mvu_done = '0;
    @(negedge clk);
    do_reset();

    // Reset state read
    apb(0, a(0, 1), 0, '0);
    check("t1_status", s_rd, 32'h0);

    // Config write / read-back on MVU2
    apb(1, a(2, 2), 2, '0);
    apb(1, a(2, 3), 2, '0);
    apb(1, a(2, 4), 8, '0);
    apb(1, a(2, 8), 32'h40, '0);
    apb(0, a(2, 2), 0, '0); check("t2_wprec", s_rd, 32'd2);
    apb(0, a(2, 3), 0, '0); check("t2_iprec", s_rd, 32'd2);
    apb(0, a(2, 4), 0, '0); check("t2_oprec", s_rd, 32'd8);
    apb(0, a(2, 8), 0, '0); check("t2_countdown", s_rd, 32'h40);
    check("t2_oprec_slice", oprec[14:10], 5'd8);
    apb(1, a(2, 5), 32'hFFFF_FFFF, '0);
    apb(0, a(2, 5), 0, '0); check("t2_wbaddr_trunc", s_rd, 32'h7FFF);

    // Start / done / interrupt on MVU1
    apb(1, a(1, 9), 1, '0);
    apb(1, a(1, 0), 1, '0);
    check("t3_start_pulse", s_start, 8'h02);
    idle(1);
    check("t3_start_once", s_start, 8'h00);
    apb(0, a(1, 1), 0, '0); check("t3_status_busy", s_rd, 32'h1);
    cycle(0, 0, 0, 0, 0, 8'h02);
    check("t3_irq_set", s_irq[1], 1'b1);
    apb(0, a(1, 1), 0, '0); check("t3_status_irq", s_rd, 32'h2);
    apb(1, a(1, 1), 2, '0);
    check("t3_irq_clr", s_irq[1], 1'b0);

    // Start while busy is rejected
    apb(1, a(1, 0), 1, '0);
    apb(1, a(1, 0), 1, '0);
    check("t4_err", s_err, 1'b1);
    check("t4_no_pulse", s_start, 8'h00);
    // Done together with W1C: the new completion keeps irq set
    apb(1, a(1, 1), 2, 8'h02);
    check("t4_set_wins", s_irq[1], 1'b1);
    apb(1, a(1, 1), 2, '0);

    // Decode and value errors
    apb(0, 32'h800, 0, '0); check("t5_mvu_range", s_err, 1'b1);
    apb(1, a(2, 2), 0, '0); check("t5_prec0_err", s_err, 1'b1);
    apb(1, a(2, 2), 17, '0); check("t5_prec17_err", s_err, 1'b1);
    apb(0, a(2, 2), 0, '0); check("t5_prec_kept", s_rd, 32'd2);
    apb(1, a(2, 2), 16, '0); check("t5_prec16_ok", s_err, 1'b0);
    apb(0, a(2, 11), 0, '0); check("t5_unmapped", s_err, 1'b1);

    // Busy-cycle counter
    apb(1, a(4, 0), 1, '0);
    idle(10);
    cycle(0, 0, 0, 0, 0, 8'h10);
    apb(0, a(4, 10), 0, '0);
`ifdef MVU_CSR_PERFCNT_EN
    check("t6_busycyc", s_rd, 32'd11);
    check("t6_err", s_err, 1'b0);
    apb(1, a(4, 10), 0, '0); check("t6_ro_err", s_err, 1'b1);
`else
    check("t6_unmapped", s_err, 1'b1);
`endif

    // Reset in the middle of a job; a late done is ignored
    apb(1, a(3, 9), 1, '0);
    apb(1, a(3, 0), 1, '0);
    idle(2);
    do_reset();
    cycle(0, 0, 0, 0, 0, 8'h08);
    apb(0, a(3, 1), 0, '0); check("t7_status", s_rd, 32'h0);
    check("t7_irq", s_irq, 8'h00);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [NMVU-1:0] dn;
      dn = ($urandom_range(0, 3) == 0) ? NMVU'($urandom) : '0;
      if ($urandom_range(0, 2) == 0) begin
        cycle(0, 0, 0, 0, 0, dn);
      end else begin
        int mv = $urandom_range(0, NMVU + 1);
        int r  = $urandom_range(0, 11);
        bit wr = 1'($urandom_range(0, 1));
        logic [31:0] d;
        if (r >= 2 && r <= 4)  d = $urandom_range(0, 18);
        else if (r <= 1)       d = $urandom_range(0, 3);
        else                   d = $urandom;
        apb(wr, a(mv, r) | 32'($urandom_range(0, 3)), d, dn);
      end
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
